// File: rtl/mips_lite_pkg.sv
// Shared encodings for the MIPS-lite execute slice: opcodes, function codes
// and ALU control codes.
package mips_lite_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;

endpackage

// File: rtl/mips_exec_dmem.sv
// Word-organised data memory: clocked write, asynchronous read, and an
// asynchronous active-low reset that clears every word.
module mips_exec_dmem #(
    parameter int DM_WORDS  = 64,
    parameter int DM_ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [DM_ADDR_W-3:0] word_addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);
    localparam int IDX_W = $clog2(DM_WORDS);

    logic [31:0]      mem [DM_WORDS];
    logic [IDX_W-1:0] idx;

    // Truncation gives the modulo-DM_WORDS wrap of the word address.
    assign idx = IDX_W'(word_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mips_exec_core.sv
// Single-cycle MIPS-lite execute/memory slice: main decoder, 32-bit ALU and
// word data memory. Everything but the memory write is combinational.
module mips_exec_core
    import mips_lite_pkg::*;
#(
    parameter int DM_WORDS  = 64,
    parameter int DM_ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        reg_write,
    output logic        reg_dst,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] alu_out,
    output logic        alu_zero,
    output logic        npc_jmp,
    output logic        mem_read,
    output logic        mem_write,
    output logic        illegal
);
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        alu_src;
    logic        imm_zext;
    logic [3:0]  alu_ctl;
    logic [31:0] imm_ext;
    logic [31:0] op_b;
    logic [31:0] mem_rdata;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    always_comb begin
        reg_dst   = 1'b0;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        imm_zext  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        alu_ctl   = ALU_ADDU;
        unique case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADDU) begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end else if (funct == FN_SUBU) begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    alu_ctl   = ALU_SUBU;
                end else begin
                    illegal   = 1'b1;
                end
            end
            OP_ORI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_zext  = 1'b1;
                alu_ctl   = ALU_OR;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = ALU_LUI;
            end
            OP_LW: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                mem_read  = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign npc_jmp = 1'b0;
    assign imm_ext = imm_zext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
    assign op_b    = alu_src ? imm_ext : rt_data;

    always_comb begin
        alu_out = '0;
        case (alu_ctl)
            ALU_ADDU: alu_out = rs_data + op_b;
            ALU_SUBU: alu_out = rs_data - op_b;
            ALU_OR:   alu_out = rs_data | op_b;
            ALU_LUI:  alu_out = {op_b[15:0], 16'h0};
            ALU_AND:  alu_out = rs_data & op_b;
            default:  alu_out = '0;
        endcase
    end

    assign alu_zero = (alu_out == 32'h0);
    assign wr_addr  = reg_dst ? instr[15:11] : instr[20:16];

    mips_exec_dmem #(
        .DM_WORDS  (DM_WORDS),
        .DM_ADDR_W (DM_ADDR_W)
    ) u_dmem (
        .clk       (clk),
        .rst       (rst),
        .we        (mem_write),
        .word_addr (alu_out[DM_ADDR_W-1:2]),
        .wdata     (rt_data),
        .rdata     (mem_rdata)
    );

    assign wr_data = mem_read ? mem_rdata : alu_out;

endmodule

// File: tb/tb_mips_exec_core.sv
// Scoreboard bench for mips_exec_core: expectations are queued with each
// stimulus and compared once the combinational outputs have settled.
module tb_mips_exec_core;
    localparam int S_RW   = 0;
    localparam int S_RDST = 1;
    localparam int S_WA   = 2;
    localparam int S_WD   = 3;
    localparam int S_ALU  = 4;
    localparam int S_ZERO = 5;
    localparam int S_JMP  = 6;
    localparam int S_MRD  = 7;
    localparam int S_MWR  = 8;
    localparam int S_ILL  = 9;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        reg_write, reg_dst, alu_zero, npc_jmp, mem_read, mem_write, illegal;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, alu_out;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mips_exec_core dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .npc_jmp   (npc_jmp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .illegal   (illegal)
    );

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_RW:    return {31'h0, reg_write};
            S_RDST:  return {31'h0, reg_dst};
            S_WA:    return {27'h0, wr_addr};
            S_WD:    return wr_data;
            S_ALU:   return alu_out;
            S_ZERO:  return {31'h0, alu_zero};
            S_JMP:   return {31'h0, npc_jmp};
            S_MRD:   return {31'h0, mem_read};
            S_MWR:   return {31'h0, mem_write};
            default: return {31'h0, illegal};
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Drive on the falling edge so any store completes on the following rising edge.
    task automatic apply(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                         input logic rst_v);
        exp_t e;
        @(negedge clk);
        rst     = rst_v;
        instr   = i;
        rs_data = rs;
        rt_data = rt;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, observe(e.sel), e.val);
        end
    endtask

    initial begin
        // Illegal opcode while in reset; memory must read back zero afterwards.
        expect_out("rst_ill",     S_ILL, 32'h1);
        expect_out("rst_ill_rw",  S_RW,  32'h0);
        expect_out("rst_ill_mw",  S_MWR, 32'h0);
        expect_out("rst_ill_jmp", S_JMP, 32'h0);
        apply(32'hFC000000, 32'h0, 32'h0, 1'b0);

        expect_out("rst_mem0", S_WD, 32'h0);
        apply(32'h8C230000, 32'h0, 32'h0, 1'b1);

        expect_out("addu_alu",  S_ALU,  32'h00000004);
        expect_out("addu_rw",   S_RW,   32'h1);
        expect_out("addu_rdst", S_RDST, 32'h1);
        expect_out("addu_wa",   S_WA,   32'd3);
        expect_out("addu_zero", S_ZERO, 32'h0);
        expect_out("addu_wd",   S_WD,   32'h00000004);
        expect_out("addu_ill",  S_ILL,  32'h0);
        apply(32'h00221821, 32'h00000005, 32'hFFFFFFFF, 1'b1);

        expect_out("subu_eq_alu",  S_ALU,  32'h0);
        expect_out("subu_eq_zero", S_ZERO, 32'h1);
        expect_out("subu_eq_wd",   S_WD,   32'h0);
        apply(32'h00221823, 32'h1234, 32'h1234, 1'b1);

        expect_out("subu_neg_alu",  S_ALU,  32'hFFFFFFFE);
        expect_out("subu_neg_zero", S_ZERO, 32'h0);
        apply(32'h00221823, 32'h3, 32'h5, 1'b1);

        expect_out("ori_alu",  S_ALU,  32'h0001FFFF);
        expect_out("ori_wa",   S_WA,   32'd2);
        expect_out("ori_rdst", S_RDST, 32'h0);
        expect_out("ori_rw",   S_RW,   32'h1);
        apply(32'h3422FFFF, 32'h00010000, 32'h77777777, 1'b1);

        expect_out("lui_alu", S_ALU, 32'hABCD0000);
        expect_out("lui_wa",  S_WA,  32'd3);
        apply(32'h3C03ABCD, 32'h12345678, 32'h0, 1'b1);

        expect_out("sw_alu", S_ALU, 32'h00000014);
        expect_out("sw_mw",  S_MWR, 32'h1);
        expect_out("sw_rw",  S_RW,  32'h0);
        expect_out("sw_mrd", S_MRD, 32'h0);
        apply(32'hAC220004, 32'h10, 32'hDEADBEEF, 1'b1);

        expect_out("lw_wd",  S_WD,  32'hDEADBEEF);
        expect_out("lw_mrd", S_MRD, 32'h1);
        expect_out("lw_wa",  S_WA,  32'd3);
        expect_out("lw_rw",  S_RW,  32'h1);
        expect_out("lw_mw",  S_MWR, 32'h0);
        apply(32'h8C230004, 32'h10, 32'h0, 1'b1);

        expect_out("lw_misalign", S_WD, 32'hDEADBEEF);
        apply(32'h8C230004, 32'h13, 32'h0, 1'b1);

        expect_out("lw_wrap5", S_WD, 32'hDEADBEEF);
        apply(32'h8C230000, 32'h314, 32'h0, 1'b1);

        expect_out("sw_wrap_alu", S_ALU, 32'h00000100);
        apply(32'hAC220000, 32'h100, 32'hCAFEF00D, 1'b1);

        expect_out("lw_neg_alu", S_ALU, 32'h0);
        expect_out("lw_neg_wd",  S_WD,  32'hCAFEF00D);
        apply(32'h8C23FFFC, 32'h4, 32'h0, 1'b1);

        expect_out("ill_funct",    S_ILL, 32'h1);
        expect_out("ill_funct_rw", S_RW,  32'h0);
        apply(32'h00221820, 32'h1, 32'h2, 1'b1);

        // Mid-cycle reset clears memory immediately.
        expect_out("midrst_w0", S_WD, 32'h0);
        apply(32'h8C230000, 32'h0, 32'h0, 1'b0);

        expect_out("midrst_w5",  S_WD,  32'h0);
        expect_out("midrst_mrd", S_MRD, 32'h1);
        apply(32'h8C230000, 32'h14, 32'h0, 1'b0);

        expect_out("sw_in_rst_mw", S_MWR, 32'h1);
        apply(32'hAC220000, 32'h0, 32'h55555555, 1'b0);

        expect_out("sw_in_rst_blocked", S_WD, 32'h0);
        apply(32'h8C230000, 32'h0, 32'h0, 1'b1);

        expect_out("post_rst_w5", S_WD, 32'h0);
        apply(32'h8C230000, 32'h14, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_exec_core.md
Name: mips_exec_core

Overview:
- Single-cycle MIPS-lite execute/memory slice. Combines the main decoder (control), the 32-bit ALU and the word data memory.
- Takes the fetched instruction and the two GPR read values from the register file.
- Returns register-writeback controls, writeback address and data, and the zero/jump flags to the PC logic.
- Supports addu, subu, ori, lui, lw and sw.

Parameters:
- DM_WORDS, 64, number of 32-bit data-memory words; a power of two, at most 64.
- DM_ADDR_W, 8, byte-address bits used for memory access; higher address bits are ignored.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-low reset
- instr  in  32  current instruction word
- rs_data  in  32  GPR[instr[25:21]]
- rt_data  in  32  GPR[instr[20:16]]
- reg_write  out  1  GPR write enable
- reg_dst  out  1  1: write address is rd; 0: write address is rt
- wr_addr  out  5  GPR write address: rd (instr[15:11]) if reg_dst, else rt (instr[20:16])
- wr_data  out  32  GPR write data: memory read data for lw, ALU result otherwise
- alu_out  out  32  ALU result
- alu_zero  out  1  1 when alu_out == 0
- npc_jmp  out  1  jump request to the next-PC logic; always 0 for the supported set
- mem_read  out  1  memory read strobe (lw)
- mem_write  out  1  memory write strobe (sw)
- illegal  out  1  instruction not in the supported set

Behaviour:
- Everything except the memory write and reset is combinational; the block has zero-cycle latency.
- Decode:
  - opcode = instr[31:26], funct = instr[5:0].
  - addu: op 0x00, funct 0x21.
  - subu: op 0x00, funct 0x23.
  - ori: op 0x0D.
  - lui: op 0x0F.
  - lw: op 0x23.
  - sw: op 0x2B.
- Control per instruction (reg_dst / reg_write / alu_src / mem_read / mem_write / alu_ctl):
  - addu: 1 / 1 / 0 / 0 / 0 / ADDU
  - subu: 1 / 1 / 0 / 0 / 0 / SUBU
  - ori: 0 / 1 / 1 / 0 / 0 / OR (imm16 zero-extended)
  - lui: 0 / 1 / 1 / 0 / 0 / LUI
  - lw: 0 / 1 / 1 / 1 / 0 / ADDU (imm16 sign-extended)
  - sw: x / 0 / 1 / 0 / 1 / ADDU (imm16 sign-extended); reg_dst is driven 0.
- Any other opcode/funct: illegal=1, reg_write=0, mem_read=0, mem_write=0, npc_jmp=0, alu_ctl=ADDU.
- ALU operands:
  - Operand A = rs_data.
  - Operand B = rt_data when alu_src=0, else the extended imm16.
- ALU operations on the 4-bit alu_ctl:
  - ADDU=0000: a+b, modulo 2^32, no overflow trap.
  - SUBU=0001: a-b, modulo 2^32.
  - OR=0010: a|b.
  - LUI=0011: {b[15:0],16'h0}.
  - AND=0100: a&b (spare).
  - Other codes: result 0.
- Data memory:
  - Byte address = alu_out[DM_ADDR_W-1:0]; word index = address[DM_ADDR_W-1:2] modulo DM_WORDS.
  - Low 2 address bits are ignored, so misaligned accesses silently word-align.
  - Address bits above DM_ADDR_W are ignored, so addresses wrap.
  - Write: on rising clk when mem_write=1 and rst=1; stores rt_data.
  - Read: asynchronous.
  - Read during write to the same word returns the old value until the clock edge, then the new value.
- Reset:
  - rst=0 asynchronously clears every memory word to 0 and blocks writes.
  - Combinational outputs follow instr throughout reset.
  - A reset asserted mid-cycle overrides a pending write.

Decomposition:
- Shared package mips_lite_pkg:
  - opcode constants OP_RTYPE, OP_ORI, OP_LUI, OP_LW, OP_SW;
  - funct constants FN_ADDU, FN_SUBU;
  - alu_ctl constants ALU_ADDU, ALU_SUBU, ALU_OR, ALU_LUI, ALU_AND.
- Decoder, ALU and operand muxing are inline in mips_exec_core.
- One sub-module is natural: mips_exec_dmem, the clocked word memory with asynchronous reset.

Test Plan:
- addu: instr=0x00221821 (addu $3,$1,$2), rs=0x00000005, rt=0xFFFFFFFF -> alu_out=0x00000004, reg_write=1, reg_dst=1, wr_addr=3, alu_zero=0.
- subu with equal operands: instr=0x00221823, rs=rt=0x1234 -> alu_out=0, alu_zero=1, wr_data=0.
- ori and lui:
  - ori, instr=0x3422FFFF, rs=0x00010000 -> alu_out=0x0001FFFF (zero-extended immediate), wr_addr=2.
  - lui, instr=0x3C03ABCD -> alu_out=0xABCD0000.
- sw then lw:
  - sw, instr=0xAC220004, rs=0x10, rt=0xDEADBEEF, one clk edge -> word index 5 written, reg_write=0.
  - lw, instr=0x8C230004, same rs -> wr_data=0xDEADBEEF, mem_read=1, wr_addr=3.
- Negative offset and wrap:
  - lw with imm=0xFFFC, rs=0x4 -> address 0, returns word 0.
  - sw to rs=0x100 -> lands on word 0.
- Reset and illegal:
  - Write word 0, then assert rst=0 between edges -> all reads return 0.
  - sw while rst=0 -> no write.
  - instr=0xFC000000 -> illegal=1, reg_write=0, mem_write=0.
